// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational FPU.
// Operands are registered at grant, the result is captured after a per-op settle count and held until consumed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no operation in flight; the only state that grants
// S_WAIT | operands on the FPU ports, counting down the settle time
// S_RESP | result captured; held on the response port until ready
module fpu_arbiter #(
    parameter int ADDSUB_WAIT = 1,
    parameter int MUL_WAIT    = 2,
    parameter int DIV_WAIT    = 4
) (
    input  logic        i_w_clk,
    input  logic        i_w_rst,
    input  logic [1:0]  i_w_req_valid,
    output logic [1:0]  o_w_req_ready,
    input  logic [63:0] i_w_req_op1,
    input  logic [63:0] i_w_req_op2,
    input  logic [5:0]  i_w_req_opsel,
    output logic [31:0] o_w_fpu_op1,
    output logic [31:0] o_w_fpu_op2,
    output logic [2:0]  o_w_fpu_opsel,
    input  logic [31:0] i_w_fpu_out,
    output logic        o_w_rsp_valid,
    output logic        o_w_rsp_id,
    output logic [31:0] o_w_rsp_data,
    input  logic        i_w_rsp_ready,
    output logic        o_w_busy
);

    localparam int MAX_AM   = (ADDSUB_WAIT > MUL_WAIT) ? ADDSUB_WAIT : MUL_WAIT;
    localparam int MAX_WAIT = (MAX_AM > DIV_WAIT) ? MAX_AM : DIV_WAIT;
    localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    logic             grant;
    logic             accept;
    logic [31:0]      grant_op1;
    logic [31:0]      grant_op2;
    logic [2:0]       grant_opsel;
    logic [CNT_W-1:0] grant_wait;

    function automatic logic [CNT_W-1:0] settle_for(input logic [2:0] opsel);
        logic [CNT_W-1:0] w;
        case (opsel)
            3'b000, 3'b001: w = CNT_W'(ADDSUB_WAIT);
            3'b010:         w = CNT_W'(MUL_WAIT);
            3'b011:         w = CNT_W'(DIV_WAIT);
            default:        w = '0;
        endcase
        return w;
    endfunction

    // Contention goes to rr; a lone requester wins regardless of rr.
    always_comb begin
        grant = 1'b0;
        if (i_w_req_valid == 2'b11) begin
            grant = rr;
        end else if (i_w_req_valid[1]) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        o_w_req_ready    = 2'b00;
        o_w_req_ready[0] = (state == S_IDLE) && !grant && i_w_req_valid[0];
        o_w_req_ready[1] = (state == S_IDLE) &&  grant && i_w_req_valid[1];
    end

    assign accept      = |o_w_req_ready;
    assign grant_op1   = grant ? i_w_req_op1[63:32]  : i_w_req_op1[31:0];
    assign grant_op2   = grant ? i_w_req_op2[63:32]  : i_w_req_op2[31:0];
    assign grant_opsel = grant ? i_w_req_opsel[5:3]  : i_w_req_opsel[2:0];
    assign grant_wait  = settle_for(grant_opsel);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)          state_nxt = S_WAIT;
            S_WAIT: if (cnt == '0)       state_nxt = S_RESP;
            S_RESP: if (i_w_rsp_ready)   state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state         <= S_IDLE;
            rr            <= 1'b0;
            owner         <= 1'b0;
            cnt           <= '0;
            o_w_fpu_op1   <= '0;
            o_w_fpu_op2   <= '0;
            o_w_fpu_opsel <= '0;
            o_w_rsp_id    <= 1'b0;
            o_w_rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                o_w_fpu_op1   <= grant_op1;
                o_w_fpu_op2   <= grant_op2;
                o_w_fpu_opsel <= grant_opsel;
                owner         <= grant;
                rr            <= ~grant;
                cnt           <= grant_wait;
            end
            // A zero count still spends one cycle here, so the FPU always gets a settle cycle.
            if (state == S_WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    o_w_rsp_data <= i_w_fpu_out;
                    o_w_rsp_id   <= owner;
                end
            end
        end
    end

    assign o_w_rsp_valid = (state == S_RESP);
    assign o_w_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboarded bench for fpu_arbiter: drivers push expected responses at grant,
// a negedge monitor pops and checks id, data, first-valid cycle and hold stability.
module tb_fpu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v   [2];
    logic [31:0] a1  [2];
    logic [31:0] a2  [2];
    logic [2:0]  os  [2];
    logic        rsp_ready;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [5:0]  req_opsel;
    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [2:0]  fpu_opsel;
    logic [31:0] fpu_out;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        busy;

    assign req_valid = {v[1], v[0]};
    assign req_op1   = {a1[1], a1[0]};
    assign req_op2   = {a2[1], a2[0]};
    assign req_opsel = {os[1], os[0]};

    fpu_arbiter dut (
        .i_w_clk       (clk),
        .i_w_rst       (rst),
        .i_w_req_valid (req_valid),
        .o_w_req_ready (req_ready),
        .i_w_req_op1   (req_op1),
        .i_w_req_op2   (req_op2),
        .i_w_req_opsel (req_opsel),
        .o_w_fpu_op1   (fpu_op1),
        .o_w_fpu_op2   (fpu_op2),
        .o_w_fpu_opsel (fpu_opsel),
        .i_w_fpu_out   (fpu_out),
        .o_w_rsp_valid (rsp_valid),
        .o_w_rsp_id    (rsp_id),
        .o_w_rsp_data  (rsp_data),
        .i_w_rsp_ready (rsp_ready),
        .o_w_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FPU stand-in: lookup of the hand-computed vectors, negate for opsel 100.
    function automatic logic [31:0] fpu_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [2:0] op);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        case (op)
            3'b000: if (x == 32'h3F80_0000 && y == 32'h4000_0000) r = 32'h4040_0000;
            3'b001: if (x == 32'h4040_0000 && y == 32'h3F80_0000) r = 32'h4000_0000;
            3'b010: if (x == 32'h4000_0000 && y == 32'h4040_0000) r = 32'h40C0_0000;
            3'b011: if (x == 32'h40C0_0000 && y == 32'h4000_0000) r = 32'h4040_0000;
            3'b100: r = {~x[31], x[30:0]};
            default: r = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    always_comb fpu_out = fpu_model(fpu_op1, fpu_op2, fpu_opsel);

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first-valid cycle, hold stability while stalled, contents at handshake.
    logic        seen = 1'b0;
    logic [31:0] held_data;
    logic        held_id;

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got id %0d data %h expected no response (cycle %0d)",
                         rsp_id, rsp_data, cyc);
            end else begin
                if (!seen) begin
                    check("rsp_latency", cyc, sb[0].cyc);
                    held_data = rsp_data;
                    held_id   = rsp_id;
                    seen      = 1'b1;
                end else begin
                    check("hold_data", rsp_data, held_data);
                    check("hold_id", {31'd0, rsp_id}, {31'd0, held_id});
                end
                if (rsp_ready) begin
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
                    check("rsp_data", rsp_data, sb[0].data);
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Expected first-valid cycle: k + W + 2, with k the cycle in which valid&ready is seen.
    task automatic issue(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] op, input logic [31:0] exp_data, input int w);
        int   n;
        bit   got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        v[i]  = 1'b1;
        a1[i] = x;
        a2[i] = y;
        os[i] = op;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: req%0d got no ready expected ready within 300 cycles", i);
            v[i] = 1'b0;
            return;
        end
        e.id   = i[0];
        e.data = exp_data;
        e.cyc  = cyc + w + 2;
        sb.push_back(e);
        grant_log.push_back(i[0]);
        @(posedge clk);
        #1;
        check("fpu_op1", fpu_op1, x);
        check("fpu_op2", fpu_op2, y);
        check("fpu_opsel", {29'd0, fpu_opsel}, {29'd0, op});
        v[i]  = 1'b0;
        a1[i] = 32'hDEAD_BEEF;
        a2[i] = 32'hBAAD_F00D;
        os[i] = 3'b111;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", sb.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i]  = 1'b0;
            a1[i] = 32'h0;
            a2[i] = 32'h0;
            os[i] = 3'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_fpu_op1", fpu_op1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 32'h3F80_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 1);
        drain();
        issue(1, 32'h4000_0000, 32'h4040_0000, 3'b010, 32'h40C0_0000, 2);
        drain();
        issue(0, 32'h3F80_0000, 32'h0000_0000, 3'b100, 32'hBF80_0000, 0);
        drain();

        // Simultaneous pair straight after reset: rr=0 so req0 first.
        apply_reset();
        grant_log.delete();
        fork
            issue(0, 32'h3F80_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 1);
            issue(1, 32'h4000_0000, 32'h4040_0000, 3'b010, 32'h40C0_0000, 2);
        join
        drain();
        check("pair1_first", {31'd0, grant_log[0]}, 32'd0);
        check("pair1_second", {31'd0, grant_log[1]}, 32'd1);

        // A lone req0 moves rr to 1, so the next pair serves req1 first.
        issue(0, 32'h4000_0000, 32'h0000_0000, 3'b100, 32'hC000_0000, 0);
        drain();
        grant_log.delete();
        fork
            issue(0, 32'h40C0_0000, 32'h4000_0000, 3'b011, 32'h4040_0000, 4);
            issue(1, 32'h4040_0000, 32'h3F80_0000, 3'b001, 32'h4000_0000, 1);
        join
        drain();
        check("pair2_first", {31'd0, grant_log[0]}, 32'd1);
        check("pair2_second", {31'd0, grant_log[1]}, 32'd0);

        // Divide with the consumer stalled for 5 cycles.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        issue(0, 32'h40C0_0000, 32'h4000_0000, 3'b011, 32'h4040_0000, 4);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_fpu_op1", fpu_op1, 32'h40C0_0000);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_ready", {31'd0, busy}, 32'd0);
        drain();

        // Reset during a divide's WAIT discards it.
        issue(1, 32'h40C0_0000, 32'h4000_0000, 3'b011, 32'h4040_0000, 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("wrst_busy", {31'd0, busy}, 32'd0);
        check("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("wrst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("wrst_rsp_data", rsp_data, 32'd0);
        check("wrst_fpu_op1", fpu_op1, 32'd0);
        check("wrst_fpu_op2", fpu_op2, 32'd0);
        check("wrst_fpu_opsel", {29'd0, fpu_opsel}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("wrst_still_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter ADDSUB_WAIT, default 1, settle cycles for opsel 000/001.
REQ-002 SHALL have parameter MUL_WAIT, default 2, settle cycles for opsel 010.
REQ-003 SHALL have parameter DIV_WAIT, default 4, settle cycles for opsel 011; opsel 100-111 use 0.
REQ-004 SHALL have i_w_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have i_w_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have i_w_req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-007 SHALL have o_w_req_ready  output  2  per-requester accept strobe.
REQ-008 SHALL have i_w_req_op1  input  64  packed first operands; [32i+31:32i] = requester i.
REQ-009 SHALL have i_w_req_op2  input  64  packed second operands, same packing.
REQ-010 SHALL have i_w_req_opsel  input  6  packed opsels; [3i+2:3i] = requester i.
REQ-011 SHALL have o_w_fpu_op1, o_w_fpu_op2  output  32 each  registered operands to the FPU.
REQ-012 SHALL have o_w_fpu_opsel  output  3  registered operation select to the FPU.
REQ-013 SHALL have i_w_fpu_out  input  32  combinational FPU result.
REQ-014 SHALL have o_w_rsp_valid  output  1  response valid.
REQ-015 SHALL have o_w_rsp_id  output  1  index of the requester owning the response.
REQ-016 SHALL have o_w_rsp_data  output  32  captured FPU result.
REQ-017 SHALL have i_w_rsp_ready  input  1  response consumer ready.
REQ-018 SHALL have o_w_busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT and RESP; only IDLE accepts requests.
REQ-020 SHALL grant in IDLE by round-robin: a single valid requester wins; if both are valid, the requester equal to priority pointer rr wins.
REQ-021 SHALL drive o_w_req_ready[i] combinationally high only in IDLE, only for the granted i, and only when i_w_req_valid[i] is high; at most one bit is high.
REQ-022 SHALL treat accept as valid&ready and, on accept, register op1/op2/opsel to the o_w_fpu_* ports, register the grant index as the owner, set rr to the other index, load cnt with the wait for that opsel, and go to WAIT.
REQ-023 SHALL in WAIT decrement cnt when it is nonzero; when cnt==0, capture i_w_fpu_out into o_w_rsp_data, capture the owner into o_w_rsp_id, and go to RESP.
REQ-024 SHALL give the latency as accept edge T, then o_w_rsp_valid high from cycle T+W+2, where W is the settle count for the opsel.
REQ-025 SHALL in RESP hold o_w_rsp_valid=1 and keep data and id stable until i_w_rsp_ready=1, then go to IDLE; no accept occurs in that same cycle.
REQ-026 SHALL hold the o_w_fpu_* ports stable from accept until the next accept; they are not cleared on return to IDLE.
REQ-027 SHALL sample requester inputs only at accept; changes outside the accept cycle have no effect.
REQ-028 SHALL leave rr unchanged when no accept occurs, and keep a non-granted pending request pending with no loss.
REQ-029 SHALL size cnt to hold max(ADDSUB_WAIT, MUL_WAIT, DIV_WAIT); W=0 gives exactly one WAIT cycle.

Reset
REQ-030 SHALL on i_w_rst=1 at a clock edge set state to IDLE, rr, cnt and the owner to 0, and clear o_w_rsp_valid, o_w_rsp_id, o_w_rsp_data and all o_w_fpu_* outputs to 0.
REQ-031 SHALL let reset take priority over every other event, including an accept or response handshake in the same cycle.
REQ-032 SHALL discard an operation in WAIT or RESP when reset is applied, with no response ever issued for it.

Verification
REQ-033 SHALL check: req0 add 0x3F800000+0x40000000, rsp_ready=1 -> rsp_valid at T+3, data 0x40400000, id 0.
REQ-034 SHALL check: req1 mul 0x40000000*0x40400000 -> data 0x40C00000, id 1, rsp_valid at T+4.
REQ-035 SHALL check: both valid in the same cycle after reset -> req0 served first, then req1; the next simultaneous pair serves req1 first.
REQ-036 SHALL check: div 0x40C00000/0x40000000 with rsp_ready held low for 5 cycles -> rsp_valid, data 0x40400000 and id stable throughout; IDLE one cycle after ready rises.
REQ-037 SHALL check: reset asserted during a DIV WAIT -> next cycle busy=0, rsp_valid=0, all outputs 0, and no response follows.
REQ-038 SHALL check: opsel 100 on 0x3F800000 -> data 0xBF800000 at T+2.
